// File: rtl/alu_arbiter_if.sv
// rtl/alu_arbiter_if.sv - requester, response and alu-side signal bundle for alu_arbiter
interface alu_arbiter_if #(
  parameter int DATA_LEN = 32,
  parameter int FUNC_LEN = 4
);
  logic                req0_valid;
  logic                req0_ready;
  logic [DATA_LEN-1:0] req0_a;
  logic [DATA_LEN-1:0] req0_b;
  logic [FUNC_LEN-1:0] req0_func;
  logic                req1_valid;
  logic                req1_ready;
  logic [DATA_LEN-1:0] req1_a;
  logic [DATA_LEN-1:0] req1_b;
  logic [FUNC_LEN-1:0] req1_func;
  logic                rsp0_valid;
  logic                rsp0_ready;
  logic                rsp1_valid;
  logic                rsp1_ready;
  logic [DATA_LEN-1:0] rsp_result;
  logic [DATA_LEN-1:0] alu_a;
  logic [DATA_LEN-1:0] alu_b;
  logic [FUNC_LEN-1:0] alu_func;
  logic [DATA_LEN-1:0] alu_result;

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_func,
    input  req1_valid, req1_a, req1_b, req1_func,
    input  rsp0_ready, rsp1_ready, alu_result,
    output req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_result,
    output alu_a, alu_b, alu_func
  );

  modport master (
    output req0_valid, req0_a, req0_b, req0_func,
    output req1_valid, req1_a, req1_b, req1_func,
    output rsp0_ready, rsp1_ready, alu_result,
    input  req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_result,
    input  alu_a, alu_b, alu_func
  );
endinterface

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin sharing of one external combinational alu between two requesters
module alu_arbiter #(
  parameter int DATA_LEN = 32,
  parameter int FUNC_LEN = 4
) (
  input logic          clk,
  input logic          rst,
  alu_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic                owner;
  logic                last_grant;
  logic                grant_any;
  logic                grant;
  logic                rsp_take;
  logic                req0_ready;
  logic                req1_ready;
  logic                rsp0_valid;
  logic                rsp1_valid;
  logic [DATA_LEN-1:0] a_q;
  logic [DATA_LEN-1:0] b_q;
  logic [FUNC_LEN-1:0] func_q;
  logic [DATA_LEN-1:0] result_q;

  // Ready is gated by reset so nothing is offered while the block is held in reset.
  always_comb begin
    grant_any  = 1'b0;
    grant      = 1'b0;
    state_nxt  = state;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    rsp0_valid = 1'b0;
    rsp1_valid = 1'b0;
    rsp_take   = owner ? bus.rsp1_ready : bus.rsp0_ready;
    case (state)
      IDLE: begin
        if (rst) begin
          if (bus.req0_valid && bus.req1_valid) begin
            grant_any = 1'b1;
            grant     = ~last_grant;
          end else if (bus.req0_valid) begin
            grant_any = 1'b1;
            grant     = 1'b0;
          end else if (bus.req1_valid) begin
            grant_any = 1'b1;
            grant     = 1'b1;
          end
        end
        req0_ready = grant_any && !grant;
        req1_ready = grant_any && grant;
        if (grant_any) state_nxt = EXEC;
      end
      EXEC: state_nxt = RESP;
      RESP: begin
        rsp0_valid = !owner;
        rsp1_valid = owner;
        if (rsp_take) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner      <= 1'b0;
      last_grant <= 1'b1;
      a_q        <= '0;
      b_q        <= '0;
      func_q     <= '0;
      result_q   <= '0;
    end else begin
      if (grant_any) begin
        owner      <= grant;
        last_grant <= grant;
        a_q        <= grant ? bus.req1_a    : bus.req0_a;
        b_q        <= grant ? bus.req1_b    : bus.req0_b;
        func_q     <= grant ? bus.req1_func : bus.req0_func;
      end
      if (state == EXEC) result_q <= bus.alu_result;
    end
  end

  assign bus.req0_ready = req0_ready;
  assign bus.req1_ready = req1_ready;
  assign bus.rsp0_valid = rsp0_valid;
  assign bus.rsp1_valid = rsp1_valid;
  assign bus.rsp_result = result_q;
  assign bus.alu_a      = a_q;
  assign bus.alu_b      = b_q;
  assign bus.alu_func   = func_q;

endmodule
